// File: rtl/cpu_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// cpu_clock_enable_gen
//
// Produces the single-cycle clock-enable pulse that advances the i281 CPU.
// The CPU runs on CLK_IN and qualifies every state update with CPU_CE, so no
// divided clock is needed.
//
// Modes:
//   free-run    : one CPU_CE pulse every RUN_DIV cycles of CLK_IN
//   single-step : one CPU_CE pulse per debounced press of STEP_BTN
//
// Ports:
//   CLK_IN      in   system clock
//   RST_N       in   asynchronous active-low reset
//   MODE_RUN    in   asynchronous switch: 1 = free-run, 0 = single-step
//   STEP_BTN    in   asynchronous, bouncy, active-high pushbutton
//   HALT        in   synchronous to CLK_IN; 1 = stop issuing enables
//   CPU_CE      out  registered one-cycle enable pulse
//   RUNNING     out  1 while the controller is in RUN
//   HALTED      out  1 while the controller is in HALTED
//   TICK_COUNT  out  number of CPU_CE pulses issued (wraps)
// -----------------------------------------------------------------------------
module cpu_clock_enable_gen #(
    parameter int unsigned RUN_DIV         = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TICK_W          = 16
) (
    input  logic              CLK_IN,
    input  logic              RST_N,
    input  logic              MODE_RUN,
    input  logic              STEP_BTN,
    input  logic              HALT,
    output logic              CPU_CE,
    output logic              RUNNING,
    output logic              HALTED,
    output logic [TICK_W-1:0] TICK_COUNT
);

    localparam int unsigned RUN_CW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam int unsigned DB_CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [RUN_CW-1:0] RUN_LAST = RUN_CW'(RUN_DIV - 1);
    localparam logic [DB_CW-1:0]  DB_LAST  = DB_CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STEP_IDLE     = 2'd0,
        ST_STEP_WAIT_REL = 2'd1,
        ST_RUN           = 2'd2,
        ST_HALTED        = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous board inputs.
    // Bit 0 = MODE_RUN, bit 1 = STEP_BTN.
    // -------------------------------------------------------------------------
    logic [1:0] async_in;
    logic [1:0] sync_out;
    logic       mode_s;
    logic       btn_s;

    assign async_in = {STEP_BTN, MODE_RUN};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_q;
            logic sync_q;

            always_ff @(posedge CLK_IN or negedge RST_N) begin
                if (!RST_N) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta_q <= async_in[gi];
                    sync_q <= meta_q;
                end
            end

            assign sync_out[gi] = sync_q;
        end
    endgenerate

    assign mode_s = sync_out[0];
    assign btn_s  = sync_out[1];

    // -------------------------------------------------------------------------
    // Debounce: btn_db follows btn_s only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples. Any agreeing sample restarts the count.
    // -------------------------------------------------------------------------
    logic [DB_CW-1:0] db_cnt_q, db_cnt_d;
    logic             btn_db_q, btn_db_d;
    logic             btn_db_prev_q;
    logic             press;

    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_CW'(1);
            end
        end
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
        end else begin
            db_cnt_q      <= db_cnt_d;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_q;
        end
    end

    // A press is the rising edge of the debounced level. Using the edge rather
    // than the level keeps a button held across a RUN->STEP_IDLE transition
    // from producing a spurious step.
    assign press = btn_db_q & ~btn_db_prev_q;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [RUN_CW-1:0]   run_cnt_q, run_cnt_d;
    logic                ce_q, ce_d;
    logic [TICK_W-1:0]   tick_q, tick_d;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = '0;       // counter is held at 0 outside RUN
        ce_d      = 1'b0;

        unique case (state_q)
            ST_STEP_IDLE: begin
                if (mode_s) begin
                    state_d = ST_RUN;
                end else if (press) begin
                    // The press is consumed even while halted, so releasing
                    // HALT later does not replay it.
                    state_d = ST_STEP_WAIT_REL;
                    ce_d    = ~HALT;
                end
            end

            ST_STEP_WAIT_REL: begin
                if (!btn_db_q) begin
                    state_d = ST_STEP_IDLE;
                end else if (mode_s) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Mode change first, then HALT, then terminal count: a
                // terminal count coinciding with either yields no pulse.
                if (!mode_s) begin
                    state_d = ST_STEP_IDLE;
                end else if (HALT) begin
                    state_d = ST_HALTED;
                end else if (run_cnt_q == RUN_LAST) begin
                    ce_d = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_CW'(1);
                end
            end

            ST_HALTED: begin
                // Only cycling the mode switch (or reset) leaves HALTED.
                if (!mode_s) begin
                    state_d = ST_STEP_IDLE;
                end
            end

            default: begin
                state_d = ST_STEP_IDLE;
            end
        endcase
    end

    assign tick_d = tick_q + {{(TICK_W-1){1'b0}}, ce_d};

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_STEP_IDLE;
            run_cnt_q <= '0;
            ce_q      <= 1'b0;
            tick_q    <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            ce_q      <= ce_d;
            tick_q    <= tick_d;
        end
    end

    assign CPU_CE     = ce_q;
    assign RUNNING    = (state_q == ST_RUN);
    assign HALTED     = (state_q == ST_HALTED);
    assign TICK_COUNT = tick_q;

endmodule
